// File: rtl/hazard_fwd_if.sv
// ID-stage hazard/forwarding bundle: decoded operand info in, bypass selects and stall out.
interface hazard_fwd_if #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wraddr;
  logic              id_is_load;
  logic              flush;
  logic              hold;
  logic [SEL_W-1:0]  fwd_a;
  logic [SEL_W-1:0]  fwd_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
    output id_wr_en, id_wraddr, id_is_load, flush, hold,
    input  fwd_a, fwd_b, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
    input  id_wr_en, id_wraddr, id_is_load, flush, hold,
    output fwd_a, fwd_b, stall, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// ID-stage hazard unit: keeps its own destination-tag pipe for the stages after ID and derives
// bypass selects, load-use stalls and bubble insertion from it.
module hazard_fwd_unit #(
  parameter int REG_AW   = 5,
  parameter int NSTAGE   = 3,
  parameter int LOAD_RDY = 2,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 16
) (
  input logic        clk,
  input logic        rst,
  hazard_fwd_if.slave bus
);

  if (NSTAGE < 2 || LOAD_RDY > NSTAGE || (2 ** SEL_W) <= NSTAGE) begin : g_param_check
    $error("hazard_fwd_unit: inconsistent NSTAGE/LOAD_RDY/SEL_W");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  logic [NSTAGE:1]   tag_v;
  logic [NSTAGE:1]   tag_ld;
  logic [REG_AW-1:0] tag_addr [1:NSTAGE];
  logic [CNT_W-1:0]  cnt;

  logic [SEL_W-1:0]  sel_a, sel_b;
  logic              nr_a, nr_b;
  logic              stall_int;
  logic              ent_v;

  // ID stage: youngest match wins, so scan from oldest to youngest and let later hits override
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    nr_a  = 1'b0;
    nr_b  = 1'b0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (bus.id_rs_used && bus.id_rs != '0 && tag_v[k] && tag_addr[k] == bus.id_rs) begin
        sel_a = SEL_W'(k);
        nr_a  = tag_ld[k] && (k < LOAD_RDY);
      end
      if (bus.id_rt_used && bus.id_rt != '0 && tag_v[k] && tag_addr[k] == bus.id_rt) begin
        sel_b = SEL_W'(k);
        nr_b  = tag_ld[k] && (k < LOAD_RDY);
      end
    end
  end

  assign stall_int     = bus.id_valid && (nr_a || nr_b) && !bus.flush;
  assign ent_v         = bus.id_valid && bus.id_wr_en && (bus.id_wraddr != '0)
                         && !stall_int && !bus.flush;
  assign bus.stall     = stall_int;
  assign bus.fwd_a     = (stall_int || nr_a) ? '0 : sel_a;
  assign bus.fwd_b     = (stall_int || nr_b) ? '0 : sel_b;
  assign bus.stall_cnt = cnt;

  // EXE..stage NSTAGE: tag valids and counter are the only reset state
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      cnt   <= '0;
    end else if (!bus.hold) begin
      tag_v <= {tag_v[NSTAGE-1:1], ent_v};
      if (stall_int) cnt <= sat_inc(cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.hold) begin
      tag_ld      <= {tag_ld[NSTAGE-1:1], bus.id_is_load};
      tag_addr[1] <= bus.id_wraddr;
      for (int k = 2; k <= NSTAGE; k++) tag_addr[k] <= tag_addr[k-1];
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed scenarios for hazard_fwd_unit; per-cycle expectations queued at drive time, popped at negedge.
module tb_hazard_fwd_unit;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  hazard_fwd_if #(.REG_AW(5), .SEL_W(2), .CNT_W(CW)) bus ();

  hazard_fwd_unit #(.REG_AW(5), .NSTAGE(3), .LOAD_RDY(2), .SEL_W(2), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rs; logic rsu; logic [4:0] rt; logic rtu;
    logic we; logic [4:0] wa; logic ld; logic fl; logic hd;
  } stim_t;

  stim_t        st_q [$];
  logic [9:0]   ex_q [$];
  logic [9:0]   sb_q [$];

  function automatic stim_t mk(bit v, int rs, bit rsu, int rt, bit rtu,
                               bit we, int wa, bit ld, bit fl, bit hd);
    stim_t s;
    s.v = v; s.rs = 5'(rs); s.rsu = rsu; s.rt = 5'(rt); s.rtu = rtu;
    s.we = we; s.wa = 5'(wa); s.ld = ld; s.fl = fl; s.hd = hd;
    return s;
  endfunction

  function automatic logic [9:0] ex(int fa, int fb, bit st, int cnt);
    return {2'(fa), 2'(fb), st, 5'(cnt)};
  endfunction

  task automatic apply(input stim_t s);
    bus.id_valid = s.v;  bus.id_rs = s.rs;   bus.id_rs_used = s.rsu;
    bus.id_rt = s.rt;    bus.id_rt_used = s.rtu;
    bus.id_wr_en = s.we; bus.id_wraddr = s.wa; bus.id_is_load = s.ld;
    bus.flush = s.fl;    bus.hold = s.hd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    st_q.delete();
    ex_q.delete();
  endtask

  task automatic test_reset();
    logic [9:0] want, got;
    do_reset();
    st_q.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(ex(0, 0, 0, 0));
    st_q.push_back(mk(1, 5, 1, 5, 1, 1, 6, 0, 0, 0)); ex_q.push_back(ex(0, 0, 0, 0));
    for (int i = 0; i < st_q.size(); i++) begin
      @(posedge clk); #1;
      apply(st_q[i]); sb_q.push_back(ex_q[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = {bus.fwd_a, bus.fwd_b, bus.stall, bus.stall_cnt};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset row %0d: got fa=%0d fb=%0d st=%0b cnt=%0d, want fa=%0d fb=%0d st=%0b cnt=%0d",
                 i, got[9:8], got[7:6], got[5], got[4:0], want[9:8], want[7:6], want[5], want[4:0]);
      end
    end
  endtask

  task automatic test_alu_chain();
    logic [9:0] want, got;
    do_reset();
    st_q.push_back(mk(1, 1, 1, 2, 1, 1, 3, 0, 0, 0));  ex_q.push_back(ex(0, 0, 0, 0));
    st_q.push_back(mk(1, 3, 1, 9, 1, 1, 10, 0, 0, 0)); ex_q.push_back(ex(1, 0, 0, 0));
    st_q.push_back(mk(1, 3, 1, 3, 1, 0, 0, 0, 0, 0));  ex_q.push_back(ex(2, 2, 0, 0));
    st_q.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0));  ex_q.push_back(ex(3, 0, 0, 0));
    st_q.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0));  ex_q.push_back(ex(0, 0, 0, 0));
    for (int i = 0; i < st_q.size(); i++) begin
      @(posedge clk); #1;
      apply(st_q[i]); sb_q.push_back(ex_q[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = {bus.fwd_a, bus.fwd_b, bus.stall, bus.stall_cnt};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL alu_chain row %0d: got fa=%0d fb=%0d st=%0b cnt=%0d, want fa=%0d fb=%0d st=%0b cnt=%0d",
                 i, got[9:8], got[7:6], got[5], got[4:0], want[9:8], want[7:6], want[5], want[4:0]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [9:0] want, got;
    do_reset();
    st_q.push_back(mk(1, 1, 1, 0, 0, 1, 4, 1, 0, 0)); ex_q.push_back(ex(0, 0, 0, 0));
    st_q.push_back(mk(1, 6, 1, 4, 1, 1, 5, 0, 0, 0)); ex_q.push_back(ex(0, 0, 1, 0));
    st_q.push_back(mk(1, 6, 1, 4, 1, 1, 5, 0, 0, 0)); ex_q.push_back(ex(0, 2, 0, 1));
    st_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(ex(0, 0, 0, 1));
    for (int i = 0; i < st_q.size(); i++) begin
      @(posedge clk); #1;
      apply(st_q[i]); sb_q.push_back(ex_q[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = {bus.fwd_a, bus.fwd_b, bus.stall, bus.stall_cnt};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL load_use row %0d: got fa=%0d fb=%0d st=%0b cnt=%0d, want fa=%0d fb=%0d st=%0b cnt=%0d",
                 i, got[9:8], got[7:6], got[5], got[4:0], want[9:8], want[7:6], want[5], want[4:0]);
      end
    end
  endtask

  task automatic test_youngest_wins();
    logic [9:0] want, got;
    do_reset();
    st_q.push_back(mk(1, 1, 1, 0, 0, 1, 7, 0, 0, 0)); ex_q.push_back(ex(0, 0, 0, 0));
    st_q.push_back(mk(1, 1, 1, 0, 0, 1, 7, 1, 0, 0)); ex_q.push_back(ex(0, 0, 0, 0));
    st_q.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(ex(0, 0, 1, 0));
    st_q.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(ex(2, 0, 0, 1));
    for (int i = 0; i < st_q.size(); i++) begin
      @(posedge clk); #1;
      apply(st_q[i]); sb_q.push_back(ex_q[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = {bus.fwd_a, bus.fwd_b, bus.stall, bus.stall_cnt};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL youngest row %0d: got fa=%0d fb=%0d st=%0b cnt=%0d, want fa=%0d fb=%0d st=%0b cnt=%0d",
                 i, got[9:8], got[7:6], got[5], got[4:0], want[9:8], want[7:6], want[5], want[4:0]);
      end
    end
  endtask

  task automatic test_hold_flush();
    logic [9:0] want, got;
    do_reset();
    st_q.push_back(mk(1, 1, 1, 0, 0, 1, 4, 1, 0, 0)); ex_q.push_back(ex(0, 0, 0, 0));
    for (int h = 0; h < 3; h++) begin
      st_q.push_back(mk(1, 6, 1, 4, 1, 1, 5, 0, 0, 1)); ex_q.push_back(ex(0, 0, 1, 0));
    end
    st_q.push_back(mk(1, 6, 1, 4, 1, 1, 5, 0, 0, 0)); ex_q.push_back(ex(0, 0, 1, 0));
    st_q.push_back(mk(1, 6, 1, 4, 1, 1, 5, 0, 0, 0)); ex_q.push_back(ex(0, 2, 0, 1));
    st_q.push_back(mk(1, 0, 0, 0, 0, 1, 8, 0, 1, 0)); ex_q.push_back(ex(0, 0, 0, 1));
    st_q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(ex(0, 0, 0, 1));
    st_q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(ex(0, 0, 0, 1));
    st_q.push_back(mk(1, 1, 1, 0, 0, 1, 9, 1, 0, 0)); ex_q.push_back(ex(0, 0, 0, 1));
    st_q.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 1, 0)); ex_q.push_back(ex(0, 0, 0, 1));
    st_q.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(ex(2, 0, 0, 1));
    for (int i = 0; i < st_q.size(); i++) begin
      @(posedge clk); #1;
      apply(st_q[i]); sb_q.push_back(ex_q[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = {bus.fwd_a, bus.fwd_b, bus.stall, bus.stall_cnt};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL hold_flush row %0d: got fa=%0d fb=%0d st=%0b cnt=%0d, want fa=%0d fb=%0d st=%0b cnt=%0d",
                 i, got[9:8], got[7:6], got[5], got[4:0], want[9:8], want[7:6], want[5], want[4:0]);
      end
    end
  endtask

  task automatic test_r0_unused_sat();
    logic [9:0] want, got;
    int c = 0;
    int cmax = (1 << CW) - 1;
    do_reset();
    st_q.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0));   ex_q.push_back(ex(0, 0, 0, 0));
    st_q.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));   ex_q.push_back(ex(0, 0, 0, 0));
    st_q.push_back(mk(1, 1, 1, 0, 0, 1, 11, 0, 0, 0));  ex_q.push_back(ex(0, 0, 0, 0));
    st_q.push_back(mk(1, 11, 1, 11, 0, 0, 0, 0, 0, 0)); ex_q.push_back(ex(1, 0, 0, 0));
    for (int n = 0; n < cmax + 4; n++) begin
      st_q.push_back(mk(1, 1, 1, 0, 0, 1, 12, 1, 0, 0)); ex_q.push_back(ex(0, 0, 0, c));
      st_q.push_back(mk(1, 0, 0, 12, 1, 0, 0, 0, 0, 0)); ex_q.push_back(ex(0, 0, 1, c));
      c = (c < cmax) ? c + 1 : cmax;
      st_q.push_back(mk(1, 0, 0, 12, 1, 0, 0, 0, 0, 0)); ex_q.push_back(ex(0, 2, 0, c));
    end
    for (int i = 0; i < st_q.size(); i++) begin
      @(posedge clk); #1;
      apply(st_q[i]); sb_q.push_back(ex_q[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = {bus.fwd_a, bus.fwd_b, bus.stall, bus.stall_cnt};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL r0_sat row %0d: got fa=%0d fb=%0d st=%0b cnt=%0d, want fa=%0d fb=%0d st=%0b cnt=%0d",
                 i, got[9:8], got[7:6], got[5], got[4:0], want[9:8], want[7:6], want[5], want[4:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest_wins();
    test_hold_flush();
    test_r0_unused_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
